// File: rtl/life_stepper.sv
// life_stepper: computes one Conway (B3/S23) generation on a toroidal arena.
// Reads each source row through a 1-cycle synchronous read port, keeps a
// three-row sliding window (top/mid/bot) and writes each next-generation row
// to the destination arena, one write strobe per row.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start / ready       request one generation / idle and accepting start
//   src_row             row address to the source arena
//   src_columns         source row data, valid 1 cycle after src_row
//   dst_row             row address to the destination arena
//   dst_columns_new     next-generation row data
//   dst_write           destination write strobe, 1 cycle per row
//   gen_count           completed generations since reset (wraps)
module life_stepper #(
    parameter int unsigned ARENA_WIDTH  = 48,
    parameter int unsigned ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    output logic [7:0]             src_row,
    input  logic [ARENA_WIDTH-1:0] src_columns,
    output logic [7:0]             dst_row,
    output logic [ARENA_WIDTH-1:0] dst_columns_new,
    output logic                   dst_write,
    output logic [31:0]            gen_count
);

    localparam int unsigned W     = ARENA_WIDTH;
    localparam int unsigned H     = ARENA_HEIGHT;
    localparam int unsigned ROW_W = 8;
    localparam int unsigned IDX_W = 9;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD0 = 3'd1;
    localparam logic [2:0] S_LOAD1 = 3'd2;
    localparam logic [2:0] S_LOAD2 = 3'd3;
    localparam logic [2:0] S_LOAD3 = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_SHIFT = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [W-1:0]     top_q, top_d;
    logic [W-1:0]     mid_q, mid_d;
    logic [W-1:0]     bot_q, bot_d;
    logic             ready_q, ready_d;
    logic [ROW_W-1:0] src_row_q, src_row_d;
    logic [ROW_W-1:0] dst_row_q, dst_row_d;
    logic [W-1:0]     dst_cols_q, dst_cols_d;
    logic             dst_write_q, dst_write_d;
    logic [31:0]      gen_count_q, gen_count_d;
    logic [W-1:0]     next_gen;

    // Row index modulo H; idx is always below 2H.
    function automatic logic [ROW_W-1:0] wrap_row(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] w;
        w = (idx >= IDX_W'(H)) ? idx - IDX_W'(H) : idx;
        return w[ROW_W-1:0];
    endfunction

    // Window rows as they will be while in the next state.
    always_comb begin
        top_d = top_q;
        mid_d = mid_q;
        bot_d = bot_q;
        r_d   = r_q;
        case (state_q)
            S_LOAD1: top_d = src_columns;
            S_LOAD2: mid_d = src_columns;
            S_LOAD3: begin
                bot_d = src_columns;
                r_d   = '0;
            end
            S_SHIFT: begin
                top_d = mid_q;
                mid_d = bot_q;
                bot_d = src_columns;
                r_d   = r_q + ROW_W'(1);
            end
            default: ;
        endcase
    end

    // B3/S23 rule on the upcoming window; columns wrap around.
    for (genvar c = 0; c < W; c++) begin : g_cell
        localparam int unsigned LF = (c == 0) ? W - 1 : c - 1;
        localparam int unsigned RT = (c == W - 1) ? 0 : c + 1;
        logic [3:0] n;
        assign n = 4'(top_d[LF]) + 4'(top_d[c]) + 4'(top_d[RT])
                 + 4'(mid_d[LF])                + 4'(mid_d[RT])
                 + 4'(bot_d[LF]) + 4'(bot_d[c]) + 4'(bot_d[RT]);
        assign next_gen[c] = (n == 4'd3) | (mid_d[c] & (n == 4'd2));
    end

    // Next state and the registered outputs that go with it.
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        src_row_d   = src_row_q;
        dst_row_d   = dst_row_q;
        dst_cols_d  = dst_cols_q;
        dst_write_d = 1'b0;
        gen_count_d = gen_count_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    state_d   = S_LOAD0;
                    ready_d   = 1'b0;
                    src_row_d = LAST_ROW;
                end
            end
            S_LOAD0: begin
                state_d   = S_LOAD1;
                src_row_d = '0;
            end
            S_LOAD1: begin
                state_d   = S_LOAD2;
                src_row_d = ROW_W'(1);
            end
            S_LOAD2: state_d = S_LOAD3;
            S_LOAD3: begin
                state_d     = S_WRITE;
                dst_write_d = 1'b1;
                dst_row_d   = '0;
                dst_cols_d  = next_gen;
                src_row_d   = wrap_row(IDX_W'(2));
            end
            S_WRITE: begin
                if (r_q == LAST_ROW) begin
                    state_d     = S_IDLE;
                    ready_d     = 1'b1;
                    gen_count_d = gen_count_q + 32'd1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                state_d     = S_WRITE;
                dst_write_d = 1'b1;
                dst_row_d   = r_d;
                dst_cols_d  = next_gen;
                // Row fetched here lands in bot on the following SHIFT.
                src_row_d   = wrap_row(IDX_W'(r_q) + IDX_W'(3));
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            top_q       <= '0;
            mid_q       <= '0;
            bot_q       <= '0;
            ready_q     <= 1'b1;
            src_row_q   <= '0;
            dst_row_q   <= '0;
            dst_cols_q  <= '0;
            dst_write_q <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            ready_q     <= ready_d;
            src_row_q   <= src_row_d;
            dst_row_q   <= dst_row_d;
            dst_cols_q  <= dst_cols_d;
            dst_write_q <= dst_write_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign ready           = ready_q;
    assign src_row         = src_row_q;
    assign dst_row         = dst_row_q;
    assign dst_columns_new = dst_cols_q;
    assign dst_write       = dst_write_q;
    assign gen_count       = gen_count_q;

endmodule

// File: tb/tb_life_stepper.sv
// Bench for life_stepper: source/destination arena models, a 2-D Life
// reference computed directly from the arena contents, and directed patterns.
module tb_life_stepper;

    localparam int unsigned W = 48;
    localparam int unsigned H = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [7:0]   src_row;
    logic [W-1:0] src_columns;
    logic [7:0]   dst_row;
    logic [W-1:0] dst_columns_new;
    logic         dst_write;
    logic [31:0]  gen_count;

    logic [W-1:0] src_mem [H];
    logic [W-1:0] dst_mem [H];
    logic [W-1:0] exp_mem [H];

    int tests   = 0;
    int fails   = 0;
    int wr_cnt  = 0;
    int exp_gen = 0;

    always #5 clk = ~clk;

    life_stepper #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ready           (ready),
        .src_row         (src_row),
        .src_columns     (src_columns),
        .dst_row         (dst_row),
        .dst_columns_new (dst_columns_new),
        .dst_write       (dst_write),
        .gen_count       (gen_count)
    );

    // Source arena: synchronous read, one cycle latency.
    always @(posedge clk)
        src_columns <= (src_row < H) ? src_mem[src_row] : {W{1'bx}};

    // Destination arena.
    always @(posedge clk)
        if (dst_write && dst_row < H) dst_mem[dst_row] <= dst_columns_new;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference generation straight from the neighbour-count rule on a torus.
    task automatic compute_model();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(src_mem[(r + dr + H) % H][(c + dc + W) % W]);
                exp_mem[r][c] = (n == 3) || (src_mem[r][c] && n == 2);
            end
        end
    endtask

    // Every write must come in row order and carry the reference row.
    always @(negedge clk) begin
        if (!reset && dst_write) begin
            check("write_row_order", 64'(dst_row), 64'(wr_cnt));
            if (dst_row < H)
                check("write_row_data", 64'(dst_columns_new), 64'(exp_mem[dst_row]));
            wr_cnt++;
        end
    end

    task automatic clear_src();
        for (int r = 0; r < H; r++) src_mem[r] = '0;
    endtask

    // One generation; optional start pulse or reset at edge index k after acceptance.
    task automatic run_gen(input string name, input int pulse_at, input int reset_at);
        int k;
        bit done;
        compute_model();
        for (int r = 0; r < H; r++) dst_mem[r] = {(W/2){2'b10}};
        wr_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        done = 1'b0;
        while (!done && k < 200) begin
            if (ready) begin
                done = 1'b1;
            end else if (k == reset_at) begin
                check({name, "_write_before_reset"}, 64'(dst_write), 64'd1);
                check({name, "_row_before_reset"}, 64'(dst_row), 64'd5);
                reset = 1'b1;
                #1;
                check({name, "_write_in_reset"}, 64'(dst_write), 64'd0);
                check({name, "_ready_in_reset"}, 64'(ready), 64'd1);
                check({name, "_gen_in_reset"}, 64'(gen_count), 64'd0);
                exp_gen = 0;
                @(posedge clk); #1 reset = 1'b0;
                return;
            end else begin
                start = (k == pulse_at);
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        check({name, "_ready_cycles"}, 64'(k), 64'(2 * H + 3));
        check({name, "_write_count"}, 64'(wr_cnt), 64'(H));
        exp_gen++;
        check({name, "_gen_count"}, 64'(gen_count), 64'(exp_gen));
        for (int r = 0; r < H; r++)
            check({name, "_dst_arena"}, 64'(dst_mem[r]), 64'(exp_mem[r]));
        repeat (3) @(posedge clk);
        #1;
        check({name, "_idle_ready"}, 64'(ready), 64'd1);
        check({name, "_idle_no_write"}, 64'(wr_cnt), 64'(H));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_src();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_src_row", 64'(src_row), 64'd0);
        check("rst_dst_row", 64'(dst_row), 64'd0);
        check("rst_dst_cols", 64'(dst_columns_new), 64'd0);
        check("rst_dst_write", 64'(dst_write), 64'd0);
        check("rst_gen_count", 64'(gen_count), 64'd0);
        reset = 1'b0;

        // Block still life
        clear_src();
        src_mem[2] = 48'hC00;
        src_mem[3] = 48'hC00;
        run_gen("block", -1, -1);
        check("block_row2", 64'(dst_mem[2]), 64'hC00);
        check("block_row3", 64'(dst_mem[3]), 64'hC00);
        check("block_row4", 64'(dst_mem[4]), 64'h0);

        // Vertical blinker turns horizontal
        clear_src();
        for (int r = 4; r <= 6; r++) src_mem[r] = 48'h20;
        run_gen("blinker", -1, -1);
        check("blinker_row5", 64'(dst_mem[5]), 64'h70);
        check("blinker_row4", 64'(dst_mem[4]), 64'h0);
        check("blinker_row6", 64'(dst_mem[6]), 64'h0);

        // Three corners form a block across both wraps
        clear_src();
        src_mem[0] = 48'h8000_0000_0001;
        src_mem[9] = 48'h0000_0000_0001;
        run_gen("corners", -1, -1);
        check("corners_row0", 64'(dst_mem[0]), 64'h8000_0000_0001);
        check("corners_row9", 64'(dst_mem[9]), 64'h8000_0000_0001);
        check("corners_row1", 64'(dst_mem[1]), 64'h0);
        check("corners_row8", 64'(dst_mem[8]), 64'h0);

        // Empty and full arenas
        clear_src();
        run_gen("empty", -1, -1);
        for (int r = 0; r < H; r++) src_mem[r] = '1;
        run_gen("full", -1, -1);
        check("full_row0", 64'(dst_mem[0]), 64'h0);
        check("full_row7", 64'(dst_mem[7]), 64'h0);

        // Mixed fixed pattern exercising many neighbourhoods
        for (int r = 0; r < H; r++) begin
            logic [W-1:0] pat;
            pat = 48'h9A3C_55E1_0F72;
            src_mem[r] = (pat << (r * 5)) | (pat >> (W - r * 5)) ^ 48'(r * 48'h1111_0101);
        end
        run_gen("pattern", -1, -1);

        // start pulsed during SHIFT after row 3 is ignored
        clear_src();
        for (int r = 4; r <= 6; r++) src_mem[r] = 48'h20;
        run_gen("busy_start", 11, -1);

        // Reset during row 5's WRITE, then a fresh generation
        clear_src();
        src_mem[5] = 48'h70;
        run_gen("abort", -1, 14);
        check("abort_gen_after", 64'(gen_count), 64'd0);
        run_gen("after_reset", -1, -1);
        check("after_reset_row4", 64'(dst_mem[4]), 64'h20);
        check("after_reset_row5", 64'(dst_mem[5]), 64'h20);
        check("after_reset_row6", 64'(dst_mem[6]), 64'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
